// File: rtl/simple_axi_pkg.sv
// Shared types and constants for the single-beat AXI slave memory.
// Latency: n/a (types and a pure address-decode function only).
// Backpressure: n/a.
package simple_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HALF  = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } size_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [2:0]            size;
    } req_t;

    // Out-of-range beats decode before misalignment so DECERR wins.
    function automatic resp_t access_resp(input logic [AXI_ADDR_W-1:0] addr,
                                          input logic [2:0]            size,
                                          input int unsigned           depth);
        logic [AXI_ADDR_W:0]   last_byte;
        logic [AXI_ADDR_W-1:0] mask;
        last_byte = {1'b0, addr & ~32'h7} + 33'd7;
        mask      = (32'(1) << size) - 32'(1);
        if (last_byte >= 33'(depth))
            return DECERR;
        if ((addr & mask) != '0)
            return SLVERR;
        return OKAY;
    endfunction

endpackage

// File: rtl/axi_wait_counter.sv
// Per-channel wait-state down-counter; zero flags that the channel may accept.
// Latency: loads on the cycle after load, then decrements once per cycle to 0.
// Backpressure: none; the owning FSM gates its ready on zero.
module axi_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/simple_axi_slave_mem.sv
// Single-beat AXI slave over a DEPTH-byte memory; AXI_SLAVE_DELAY_EN adds i_delay wait states.
// Latency: AW->bvalid 2 edges, AR->rvalid 1 edge (plus wait states when enabled).
// Backpressure: one outstanding write and one read; busy channels hold ready low.
module simple_axi_slave_mem
    import simple_axi_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`ifdef AXI_SLAVE_DELAY_EN
    input  logic [3:0]            i_delay,
`endif
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awsize,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [AXI_STRB_W-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arsize,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [7:0]            mem [DEPTH];
    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    req_t                  aw_req;
    resp_t                 w_resp, r_resp, b_resp_q, r_resp_q;
    logic [AXI_DATA_W-1:0] r_word, r_data_q;
    logic [IDX_W-1:0]      w_base, r_base;
    logic                  w_go, r_go;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  unused_wlast;

    assign unused_wlast = s_axi_wlast;

`ifdef AXI_SLAVE_DELAY_EN
    logic w_load, r_load;
    assign w_load = (w_next != w_state) && (w_next == W_IDLE || w_next == W_DATA);
    assign r_load = (r_next != r_state) && (r_next == R_IDLE);

    axi_wait_counter #(.W(4)) u_w_wait (
        .clk(i_clk), .rst_n(i_rst_n), .load(w_load), .value(i_delay), .zero(w_go)
    );
    axi_wait_counter #(.W(4)) u_r_wait (
        .clk(i_clk), .rst_n(i_rst_n), .load(r_load), .value(i_delay), .zero(r_go)
    );
`else
    assign w_go = 1'b1;
    assign r_go = 1'b1;
`endif

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    assign w_resp = access_resp(aw_req.addr, aw_req.size, DEPTH);
    assign r_resp = access_resp(s_axi_araddr, s_axi_arsize, DEPTH);
    assign w_base = aw_req.addr[IDX_W-1:0] & ~IDX_W'(7);
    assign r_base = s_axi_araddr[IDX_W-1:0] & ~IDX_W'(7);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs)  w_next = W_RESP;
            W_RESP:  if (b_hs)  w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Readies also drop combinationally while reset is held.
    always_comb begin
        s_axi_awready = i_rst_n && (w_state == W_IDLE) && w_go;
        s_axi_wready  = i_rst_n && (w_state == W_DATA) && w_go;
        s_axi_bvalid  = (w_state == W_RESP);
        s_axi_arready = i_rst_n && (r_state == R_IDLE) && r_go;
        s_axi_rvalid  = (r_state == R_DATA);
        s_axi_rlast   = (r_state == R_DATA);
        s_axi_bresp   = b_resp_q;
        s_axi_rresp   = r_resp_q;
        s_axi_rdata   = r_data_q;
    end

    always_comb begin
        r_word = '0;
        for (int k = 0; k < AXI_STRB_W; k++)
            r_word[8*k +: 8] = mem[r_base + IDX_W'(k)];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_req   <= '0;
            b_resp_q <= OKAY;
            r_resp_q <= OKAY;
            r_data_q <= '0;
        end else begin
            if (aw_hs)
                aw_req <= '{addr: s_axi_awaddr, size: s_axi_awsize};
            if (w_hs)
                b_resp_q <= w_resp;
            if (ar_hs) begin
                r_resp_q <= r_resp;
                r_data_q <= (r_resp == OKAY) ? r_word : '0;
            end
        end
    end

    // Reads sample mem before this edge's write lands, so a same-cycle read sees old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (w_hs && w_resp == OKAY) begin
            for (int k = 0; k < AXI_STRB_W; k++)
                if (s_axi_wstrb[k])
                    mem[w_base + IDX_W'(k)] <= s_axi_wdata[8*k +: 8];
        end
    end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Directed self-checking bench for simple_axi_slave_mem (DEPTH=128).
// Define AXI_SLAVE_DELAY_EN for both bench and RTL to exercise i_delay.
module tb_simple_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awsize;
    logic        s_axi_wvalid, s_axi_wready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arsize;
    logic        s_axi_rvalid, s_axi_rready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
`ifdef AXI_SLAVE_DELAY_EN
    logic [3:0]  i_delay;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simple_axi_slave_mem #(.DEPTH(128)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef AXI_SLAVE_DELAY_EN
        .i_delay(i_delay),
`endif
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr),   .s_axi_awsize(s_axi_awsize),
        .s_axi_wvalid(s_axi_wvalid),   .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata),     .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid),   .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr),   .s_axi_arsize(s_axi_arsize),
        .s_axi_rvalid(s_axi_rvalid),   .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata),     .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast)
    );

    task automatic wait_awready(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_axi_awready) begin got = 1; break; end
        end
    endtask

    task automatic wait_wready(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_axi_wready) begin got = 1; break; end
        end
    endtask

    task automatic wait_bvalid(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin got = 1; break; end
        end
    endtask

    task automatic wait_arready(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_axi_arready) begin got = 1; break; end
        end
    endtask

    task automatic wait_rvalid(output bit got);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_axi_rvalid) begin got = 1; break; end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [63:0] data, input logic [7:0] strb,
                            output logic [1:0] resp, output bit ok);
        bit got;
        ok = 1;
        @(posedge clk); #1;
        s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1;
        wait_awready(got); if (!got) ok = 0;
        @(posedge clk); #1; s_axi_awvalid = 0;
        wait_wready(got); if (!got) ok = 0;
        @(posedge clk); #1; s_axi_wvalid = 0; s_axi_bready = 1;
        wait_bvalid(got); if (!got) ok = 0;
        resp = s_axi_bresp;
        @(posedge clk); #1; s_axi_bready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           output logic [63:0] data, output logic [1:0] resp,
                           output bit ok);
        bit got;
        ok = 1;
        @(posedge clk); #1;
        s_axi_araddr = addr; s_axi_arsize = size; s_axi_arvalid = 1;
        wait_arready(got); if (!got) ok = 0;
        @(posedge clk); #1; s_axi_arvalid = 0; s_axi_rready = 1;
        wait_rvalid(got); if (!got) ok = 0;
        data = s_axi_rdata; resp = s_axi_rresp;
        @(posedge clk); #1; s_axi_rready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awsize = '0;
        s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1;
        s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arsize = '0;
        s_axi_rready = 0;
`ifdef AXI_SLAVE_DELAY_EN
        i_delay = 0;
`endif
        #12;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 000000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast});
        end
        checks++;
        if ({s_axi_bresp, s_axi_rresp} !== 4'b0 || s_axi_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got bresp %b rresp %b rdata %h expected 0",
                     s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_write_latency;
        logic [63:0] d; logic [1:0] r; bit ok;
        @(posedge clk); #1;
        s_axi_awaddr = 32'h2; s_axi_awsize = 3'd1; s_axi_awvalid = 1;
        // Halfword 0xABCD placed on byte lanes 2..3 to match address 2.
        s_axi_wdata = 64'h0000_0000_ABCD_0000; s_axi_wstrb = 8'h0C; s_axi_wvalid = 1;
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready} !== 2'b10) begin
            errors++;
            $display("FAIL aw_phase: got aw/w ready %b expected 10", {s_axi_awready, s_axi_wready});
        end
        @(posedge clk); #1; s_axi_awvalid = 0;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b010) begin
            errors++;
            $display("FAIL w_phase: got aw/w/b %b expected 010", {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        @(posedge clk); #1; s_axi_wvalid = 0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            errors++;
            $display("FAIL b_latency: got bvalid %b bresp %b expected 1 00", s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1;
        @(posedge clk); #1; s_axi_bready = 0;
        do_read(32'h0, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'h0000_0000_ABCD_0000 || r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_write: got %h resp %b ok %0d expected 00000000abcd0000 00", d, r, ok);
        end
    endtask

    task automatic test_read_latency;
        logic [1:0] r; bit ok;
        do_write(32'h8, 3'd3, 64'h11DD11DD22EE22EE, 8'hFF, r, ok);
        checks++;
        if (!ok || r !== 2'b00) begin
            errors++;
            $display("FAIL dword_write: got resp %b ok %0d expected 00", r, ok);
        end
        @(posedge clk); #1;
        s_axi_araddr = 32'h8; s_axi_arsize = 3'd3; s_axi_arvalid = 1;
        @(negedge clk);
        checks++;
        if ({s_axi_arready, s_axi_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL ar_phase: got ar/r %b expected 10", {s_axi_arready, s_axi_rvalid});
        end
        @(posedge clk); #1; s_axi_arvalid = 0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== 1'b1 || s_axi_rresp !== 2'b00 ||
            s_axi_rdata !== 64'h11DD11DD22EE22EE) begin
            errors++;
            $display("FAIL r_latency: got v %b last %b resp %b data %h expected 1 1 00 11dd11dd22ee22ee",
                     s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 64'h11DD11DD22EE22EE || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL r_hold: got v %b data %h arready %b expected 1 11dd11dd22ee22ee 0",
                     s_axi_rvalid, s_axi_rdata, s_axi_arready);
        end
        s_axi_rready = 1;
        @(posedge clk); #1; s_axi_rready = 0;
        checks++;
        if (s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_release: got rvalid %b expected 0", s_axi_rvalid);
        end
    endtask

    task automatic test_errors;
        logic [63:0] d; logic [1:0] r; bit ok;
        logic [31:0] a_tab [6] = '{32'h80, 32'h0A, 32'h09, 32'h78, 32'h7C, 32'hF9};
        logic [2:0]  s_tab [6] = '{3'd3, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
        logic [63:0] d_tab [6] = '{64'h0, 64'h11DD11DD22EE22EE, 64'h0, 64'h0, 64'h0, 64'h0};
        logic [1:0]  r_tab [6] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
        do_write(32'h4, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r, ok);
        checks++;
        if (!ok || r !== 2'b10) begin
            errors++;
            $display("FAIL misaligned_write: got resp %b ok %0d expected 10", r, ok);
        end
        do_write(32'h80, 3'd0, 64'hFF, 8'h01, r, ok);
        checks++;
        if (!ok || r !== 2'b11) begin
            errors++;
            $display("FAIL decerr_write: got resp %b ok %0d expected 11", r, ok);
        end
        do_read(32'h0, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'h0000_0000_ABCD_0000) begin
            errors++;
            $display("FAIL err_no_write: got %h expected 00000000abcd0000", d);
        end
        for (int i = 0; i < 6; i++) begin
            do_read(a_tab[i], s_tab[i], d, r, ok);
            checks++;
            if (!ok || d !== d_tab[i] || r !== r_tab[i]) begin
                errors++;
                $display("FAIL read_decode[%0d]: addr %h got %h resp %b expected %h %b",
                         i, a_tab[i], d, r, d_tab[i], r_tab[i]);
            end
        end
    endtask

    task automatic test_back_pressure;
        logic [63:0] d; logic [1:0] r; bit ok, got;
        @(posedge clk); #1;
        s_axi_awaddr = 32'h18; s_axi_awsize = 3'd0; s_axi_awvalid = 1;
        s_axi_wdata = 64'h55; s_axi_wstrb = 8'h01; s_axi_wvalid = 1;
        wait_awready(got);
        @(posedge clk); #1; s_axi_awvalid = 0;
        wait_wready(got);
        @(posedge clk); #1; s_axi_wvalid = 0;
        s_axi_awaddr = 32'h20; s_axi_awvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_awready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall[%0d]: got bvalid %b bresp %b awready %b expected 1 00 0",
                         i, s_axi_bvalid, s_axi_bresp, s_axi_awready);
            end
            @(posedge clk); #1;
        end
        s_axi_bready = 1;
        @(posedge clk); #1; s_axi_bready = 0;
        @(negedge clk);
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL aw_resume: got awready %b bvalid %b expected 1 0", s_axi_awready, s_axi_bvalid);
        end
        @(posedge clk); #1; s_axi_awvalid = 0;
        s_axi_wdata = 64'hA5; s_axi_wstrb = 8'h01; s_axi_wvalid = 1;
        wait_wready(got);
        @(posedge clk); #1; s_axi_wvalid = 0; s_axi_bready = 1;
        wait_bvalid(got);
        @(posedge clk); #1; s_axi_bready = 0;
        do_read(32'h18, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'h55) begin
            errors++;
            $display("FAIL first_write: got %h expected 55", d);
        end
        do_read(32'h20, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'hA5) begin
            errors++;
            $display("FAIL stalled_write: got %h expected a5", d);
        end
    endtask

    task automatic test_overlap;
        logic [63:0] d; logic [1:0] r; bit ok, got;
        do_write(32'h10, 3'd3, 64'h0102030405060708, 8'hFF, r, ok);
        @(posedge clk); #1;
        s_axi_awaddr = 32'h10; s_axi_awsize = 3'd3; s_axi_awvalid = 1;
        wait_awready(got);
        @(posedge clk); #1; s_axi_awvalid = 0;
        s_axi_wdata = 64'hFFFF_FFFF_FFFF_FFFF; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1;
        s_axi_araddr = 32'h10; s_axi_arsize = 3'd3; s_axi_arvalid = 1;
        @(negedge clk);
        checks++;
        if ({s_axi_wready, s_axi_arready} !== 2'b11) begin
            errors++;
            $display("FAIL overlap_ready: got w/ar %b expected 11", {s_axi_wready, s_axi_arready});
        end
        @(posedge clk); #1; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_rready = 1; s_axi_bready = 1;
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_bvalid !== 1'b1 || s_axi_rdata !== 64'h0102030405060708) begin
            errors++;
            $display("FAIL read_before_write: got rv %b bv %b data %h expected 1 1 0102030405060708",
                     s_axi_rvalid, s_axi_bvalid, s_axi_rdata);
        end
        @(posedge clk); #1; s_axi_rready = 0; s_axi_bready = 0;
        do_read(32'h10, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL overlap_write: got %h expected ffffffffffffffff", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d; logic [1:0] r; bit ok, got, saw_b;
        logic [31:0] a_tab [3] = '{32'h28, 32'h0, 32'h10};
        @(posedge clk); #1;
        s_axi_awaddr = 32'h28; s_axi_awsize = 3'd3; s_axi_awvalid = 1;
        wait_awready(got);
        @(posedge clk); #1; s_axi_awvalid = 0;
        s_axi_wdata = 64'hDEAD; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1;
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0 ||
            s_axi_bresp !== 2'b00 || s_axi_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got rdy/vld %b bresp %b rdata %h expected 0",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid},
                     s_axi_bresp, s_axi_rdata);
        end
        s_axi_wvalid = 0;
        @(negedge clk); rst_n = 1;
        saw_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) saw_b = 1;
        end
        checks++;
        if (saw_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_b: got bvalid seen %b expected 0", saw_b);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(a_tab[i], 3'd3, d, r, ok);
            checks++;
            if (!ok || d !== 64'h0 || r !== 2'b00) begin
                errors++;
                $display("FAIL reset_clear[%0d]: addr %h got %h resp %b expected 0 00", i, a_tab[i], d, r);
            end
        end
    endtask

`ifdef AXI_SLAVE_DELAY_EN
    task automatic test_delay;
        logic [63:0] d; logic [1:0] r; bit ok; int n;
        do_write(32'h10, 3'd3, 64'h0BADF00D_CAFEF00D, 8'hFF, r, ok);
        i_delay = 4'd5;
        do_read(32'h0, 3'd3, d, r, ok);
        // do_read returns one edge after the R handshake that re-entered R_IDLE.
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (s_axi_arready) break;
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL delay_arready: got %0d cycles expected 6 after handshake edge", n);
        end
        do_read(32'h10, 3'd3, d, r, ok);
        checks++;
        if (!ok || d !== 64'h0BADF00D_CAFEF00D || r !== 2'b00) begin
            errors++;
            $display("FAIL delay_data: got %h resp %b ok %0d expected 0badf00dcafef00d 00", d, r, ok);
        end
        i_delay = 4'd0;
    endtask
`endif

    initial begin
        test_reset;
        test_write_latency;
        test_read_latency;
        test_errors;
        test_back_pressure;
        test_overlap;
`ifdef AXI_SLAVE_DELAY_EN
        test_delay;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
